// File: rtl/multiplicador_secuencial.sv
// Sequential N-bit multiplier: shift-add for unsigned operands, radix-2 Booth for signed.
// A start/done handshake drives an IDLE/RUN/DONE FSM; producto holds the last completed result.
module multiplicador_secuencial #(
  parameter int N      = 4,
  parameter bit SIGNED = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   multiplicando,
  input  logic [N-1:0]   multiplicador,
  output logic [2*N-1:0] producto,
  output logic           done,
  output logic           busy
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [N:0]    r_a;
  logic [N-1:0]  r_q;
  logic [N-1:0]  r_m;
  logic          r_q1;
  logic [CW-1:0] r_count;

  logic [N:0]    w_mext;
  logic [N:0]    w_sum;
  logic [N:0]    w_a_shift;
  logic [N-1:0]  w_q_shift;
  logic          w_load;
  logic          w_last;

  // One iteration of the datapath. A is one bit wider than the operands: it is the carry C in
  // unsigned mode and the guard bit that keeps (-2^(N-1))^2 exact in signed mode.
  always_comb begin
    w_mext = SIGNED ? {r_m[N-1], r_m} : {1'b0, r_m};
    w_sum  = r_a;
    if (SIGNED) begin
      case ({r_q[0], r_q1})
        2'b01:   w_sum = r_a + w_mext;
        2'b10:   w_sum = r_a - w_mext;
        default: w_sum = r_a;
      endcase
    end else if (r_q[0]) begin
      w_sum = r_a + w_mext;
    end
    w_a_shift = {(SIGNED ? w_sum[N] : 1'b0), w_sum[N:1]};
    w_q_shift = {w_sum[0], r_q[N-1:1]};
  end

  assign w_load = start && (r_state != RUN);
  assign w_last = (r_state == RUN) && (r_count == CW'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operands are captured only on an accepted start; producto is updated only on the final iteration.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a      <= '0;
      r_q      <= '0;
      r_m      <= '0;
      r_q1     <= 1'b0;
      r_count  <= '0;
      producto <= '0;
    end else if (w_load) begin
      r_a     <= '0;
      r_q     <= multiplicador;
      r_m     <= multiplicando;
      r_q1    <= 1'b0;
      r_count <= CW'(N);
    end else if (r_state == RUN) begin
      r_a     <= w_a_shift;
      r_q     <= w_q_shift;
      r_q1    <= r_q[0];
      r_count <= r_count - CW'(1);
      if (w_last) begin
        producto <= {w_a_shift[N-1:0], w_q_shift};
      end
    end
  end

  assign done = (r_state == DONE);
  assign busy = (r_state == RUN);

endmodule

// File: tb/tb_multiplicador_secuencial.sv
// Directed bench for multiplicador_secuencial: unsigned N=4, signed N=4 and signed N=8 instances.
module tb_multiplicador_secuencial;

  logic        clk;
  logic        reset;

  logic        startU, doneU, busyU;
  logic [3:0]  aU, bU;
  logic [7:0]  prodU;

  logic        startS4, doneS4, busyS4;
  logic [3:0]  aS4, bS4;
  logic [7:0]  prodS4;

  logic        startS8, doneS8, busyS8;
  logic [7:0]  aS8, bS8;
  logic [15:0] prodS8;

  int checks = 0;
  int errors = 0;

  multiplicador_secuencial #(.N(4), .SIGNED(1'b0)) dutU (
    .clk(clk), .reset(reset), .start(startU),
    .multiplicando(aU), .multiplicador(bU),
    .producto(prodU), .done(doneU), .busy(busyU)
  );

  multiplicador_secuencial #(.N(4), .SIGNED(1'b1)) dutS4 (
    .clk(clk), .reset(reset), .start(startS4),
    .multiplicando(aS4), .multiplicador(bS4),
    .producto(prodS4), .done(doneS4), .busy(busyS4)
  );

  multiplicador_secuencial #(.N(8), .SIGNED(1'b1)) dutS8 (
    .clk(clk), .reset(reset), .start(startS8),
    .multiplicando(aS8), .multiplicador(bS8),
    .producto(prodS8), .done(doneS8), .busy(busyS8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset values on all three instances, then IDLE must persist while start stays low.
  task automatic test_reset();
    reset = 1'b0;
    startU = 1'b0; aU = '0; bU = '0;
    startS4 = 1'b0; aS4 = '0; bS4 = '0;
    startS8 = 1'b0; aS8 = '0; bS8 = '0;
    #1;
    checks++;
    if (prodU !== 8'h00 || doneU !== 1'b0 || busyU !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_u: got prod=%0h done=%0b busy=%0b expected 0/0/0", prodU, doneU, busyU);
    end
    checks++;
    if (prodS4 !== 8'h00 || doneS4 !== 1'b0 || busyS4 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_s4: got prod=%0h done=%0b busy=%0b expected 0/0/0", prodS4, doneS4, busyS4);
    end
    checks++;
    if (prodS8 !== 16'h0000 || doneS8 !== 1'b0 || busyS8 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_s8: got prod=%0h done=%0b busy=%0b expected 0/0/0", prodS8, doneS8, busyS8);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (doneU !== 1'b0 || busyU !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_hold: got done=%0b busy=%0b expected 0/0", doneU, busyU);
    end
  endtask

  task automatic test_unsigned();
    logic [3:0] va [3] = '{4'd15, 4'd0, 4'd1};
    logic [3:0] vb [3] = '{4'd15, 4'd9, 4'd13};
    logic [7:0] vp [3] = '{8'hE1, 8'h00, 8'h0D};
    int edges;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      startU = 1'b1; aU = va[i]; bU = vb[i];
      @(negedge clk);
      startU = 1'b0;
      edges = 1;
      checks++;
      if (busyU !== 1'b1) begin
        errors++;
        $display("[TB] FAIL u_busy_run[%0d]: got %0b expected 1", i, busyU);
      end
      while (doneU !== 1'b1 && edges < 20) begin
        @(negedge clk);
        edges++;
      end
      checks++;
      if (doneU !== 1'b1) begin
        errors++;
        $display("[TB] FAIL u_timeout[%0d]: done never rose, got %0b expected 1", i, doneU);
      end
      checks++;
      if (edges != 5) begin
        errors++;
        $display("[TB] FAIL u_latency[%0d]: got %0d edges expected 5", i, edges);
      end
      checks++;
      if (prodU !== vp[i]) begin
        errors++;
        $display("[TB] FAIL u_product[%0d]: got %0h expected %0h", i, prodU, vp[i]);
      end
      checks++;
      if (busyU !== 1'b0) begin
        errors++;
        $display("[TB] FAIL u_busy_done[%0d]: got %0b expected 0", i, busyU);
      end
      @(negedge clk);
      checks++;
      if (doneU !== 1'b0 || prodU !== vp[i]) begin
        errors++;
        $display("[TB] FAIL u_pulse_hold[%0d]: got done=%0b prod=%0h expected 0/%0h", i, doneU, prodU, vp[i]);
      end
    end
  endtask

  task automatic test_signed4();
    logic [3:0] va [3] = '{4'h8, 4'h8, 4'h3};
    logic [3:0] vb [3] = '{4'h8, 4'h7, 4'hB};
    logic [7:0] vp [3] = '{8'h40, 8'hC8, 8'hF1};
    int edges;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      startS4 = 1'b1; aS4 = va[i]; bS4 = vb[i];
      @(negedge clk);
      startS4 = 1'b0;
      edges = 1;
      while (doneS4 !== 1'b1 && edges < 20) begin
        @(negedge clk);
        edges++;
      end
      checks++;
      if (doneS4 !== 1'b1 || edges != 5) begin
        errors++;
        $display("[TB] FAIL s4_latency[%0d]: got done=%0b after %0d edges expected 1 after 5", i, doneS4, edges);
      end
      checks++;
      if (prodS4 !== vp[i]) begin
        errors++;
        $display("[TB] FAIL s4_product[%0d]: got %0h expected %0h", i, prodS4, vp[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_signed8();
    logic [7:0]  va [2] = '{8'h80, 8'h7F};
    logic [7:0]  vb [2] = '{8'h80, 8'hFF};
    logic [15:0] vp [2] = '{16'h4000, 16'hFF81};
    int edges;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      startS8 = 1'b1; aS8 = va[i]; bS8 = vb[i];
      @(negedge clk);
      startS8 = 1'b0;
      edges = 1;
      while (doneS8 !== 1'b1 && edges < 30) begin
        @(negedge clk);
        edges++;
      end
      checks++;
      if (doneS8 !== 1'b1 || edges != 9) begin
        errors++;
        $display("[TB] FAIL s8_latency[%0d]: got done=%0b after %0d edges expected 1 after 9", i, doneS8, edges);
      end
      checks++;
      if (prodS8 !== vp[i]) begin
        errors++;
        $display("[TB] FAIL s8_product[%0d]: got %0h expected %0h", i, prodS8, vp[i]);
      end
      @(negedge clk);
    end
  endtask

  // A second start and new operands during RUN must not disturb the running 6x7.
  task automatic test_start_during_run();
    int doneCount = 0;
    int firstDone = 0;
    @(negedge clk);
    startU = 1'b1; aU = 4'd6; bU = 4'd7;
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      if (e == 1) startU = 1'b0;
      if (e == 2) begin startU = 1'b1; aU = 4'd15; bU = 4'd15; end
      if (e == 3) begin startU = 1'b0; aU = 4'd3; bU = 4'd3; end
      if (doneU === 1'b1) begin
        doneCount++;
        if (firstDone == 0) firstDone = e;
        checks++;
        if (prodU !== 8'd42) begin
          errors++;
          $display("[TB] FAIL midrun_product: got %0d expected 42", prodU);
        end
      end
    end
    checks++;
    if (doneCount != 1) begin
      errors++;
      $display("[TB] FAIL midrun_done_count: got %0d expected 1", doneCount);
    end
    checks++;
    if (firstDone != 5) begin
      errors++;
      $display("[TB] FAIL midrun_latency: got %0d expected 5", firstDone);
    end
  endtask

  // With start held high, DONE goes straight back to RUN: done every 5 cycles, busy low only in DONE.
  task automatic test_back_to_back();
    logic expDone;
    @(negedge clk);
    startU = 1'b1; aU = 4'd3; bU = 4'd5;
    for (int e = 1; e <= 10; e++) begin
      @(negedge clk);
      expDone = (e == 5) || (e == 10);
      checks++;
      if (doneU !== expDone || busyU !== !expDone) begin
        errors++;
        $display("[TB] FAIL b2b_flags[%0d]: got done=%0b busy=%0b expected %0b/%0b", e, doneU, busyU, expDone, !expDone);
      end
      if (e == 1) begin aU = 4'd2; bU = 4'd2; end
      if (e == 5 || e == 7) begin
        checks++;
        if (prodU !== 8'd15) begin
          errors++;
          $display("[TB] FAIL b2b_first[%0d]: got %0d expected 15", e, prodU);
        end
      end
      if (e == 10) begin
        checks++;
        if (prodU !== 8'd4) begin
          errors++;
          $display("[TB] FAIL b2b_second: got %0d expected 4", prodU);
        end
      end
    end
    startU = 1'b0;
    @(negedge clk);
    checks++;
    if (doneU !== 1'b0 || busyU !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_idle: got done=%0b busy=%0b expected 0/0", doneU, busyU);
    end
  endtask

  task automatic test_reset_mid_run();
    int edges;
    @(negedge clk);
    startU = 1'b1; aU = 4'd9; bU = 4'd9;
    @(negedge clk);
    startU = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (prodU !== 8'h00 || doneU !== 1'b0 || busyU !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrun_reset: got prod=%0h done=%0b busy=%0b expected 0/0/0", prodU, doneU, busyU);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    startU = 1'b1; aU = 4'd5; bU = 4'd5;
    @(negedge clk);
    startU = 1'b0;
    edges = 1;
    while (doneU !== 1'b1 && edges < 20) begin
      @(negedge clk);
      edges++;
    end
    checks++;
    if (doneU !== 1'b1 || edges != 5) begin
      errors++;
      $display("[TB] FAIL post_reset_latency: got done=%0b after %0d edges expected 1 after 5", doneU, edges);
    end
    checks++;
    if (prodU !== 8'd25) begin
      errors++;
      $display("[TB] FAIL post_reset_product: got %0d expected 25", prodU);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed4();
    test_signed8();
    test_start_during_run();
    test_back_to_back();
    test_reset_mid_run();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
